// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: pipelined Rijndael ShiftRows / InvShiftRows stage.
// The byte permutation is applied combinationally on the way into stage 1;
// later stages only carry state, tag and valid. Flow control is valid/ready
// with a combinational ready chain so bubbles collapse and a full pipe can
// still move one beat per cycle.
module shift_rows_pipe #(
  parameter int NB     = 4,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_inv,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic [32*NB-1:0]    in_state,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TAG_W-1:0]    out_tag,
  output logic [32*NB-1:0]    out_state,
  output logic                busy
);

  localparam int W = 32 * NB;

  // Refuse to build with unsupported geometry instead of clamping.
  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("shift_rows_pipe: STAGES must be in 1..4");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("shift_rows_pipe: TAG_W must be at least 1");
  end

  // Byte k = 4c+r sits at bits [W-1-8k -: 8]. Row r rotates left by s(r)
  // columns in the forward direction and right by s(r) in the inverse one.
  // The 256-bit block uses the wider offsets 0,1,3,4.
  function automatic logic [W-1:0] shift_state(input logic [W-1:0] s, input logic inv);
    logic [W-1:0] res;
    int           off;
    int           src;
    res = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        off = (NB == 8 && r >= 2) ? r + 1 : r;
        src = inv ? (c - off + NB) % NB : (c + off) % NB;
        res[W-1-8*(4*c+r) -: 8] = s[W-1-8*(4*src+r) -: 8];
      end
    end
    return res;
  endfunction

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] adv;
  logic [W-1:0]      state_q [STAGES];
  logic [W-1:0]      state_d [STAGES];
  logic [TAG_W-1:0]  tag_q   [STAGES];
  logic [TAG_W-1:0]  tag_d   [STAGES];
  logic [W-1:0]      shifted;

  // Permutation of the incoming state, selected per beat by in_inv.
  always_comb begin
    shifted = shift_state(in_state, in_inv);
  end

  // Ready chain from the output back to stage 1: a stage may advance when it
  // is empty or when the stage after it (or the consumer) takes its beat.
  always_comb begin
    logic chain;
    adv   = '0;
    chain = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv[i] = !valid_q[i] || chain;
      chain  = adv[i];
    end
  end

  // Next-state for every stage; data only loads when a real beat moves in.
  always_comb begin
    valid_d = valid_q;
    state_d = state_q;
    tag_d   = tag_q;
    if (adv[0]) begin
      valid_d[0] = in_valid;
      if (in_valid) begin
        state_d[0] = shifted;
        tag_d[0]   = in_tag;
      end
    end
    for (int i = 1; i < STAGES; i++) begin
      if (adv[i]) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1]) begin
          state_d[i] = state_q[i-1];
          tag_d[i]   = tag_q[i-1];
        end
      end
    end
  end

  // Pipeline registers; reset drops every in-flight beat immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        state_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      state_q <= state_d;
      tag_q   <= tag_d;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_q[STAGES-1];
  assign out_state = state_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign busy      = |valid_q;

endmodule
